// File: rtl/pnr_pkg.sv
// Shared widths, state encoding and sample type for the PNR peak-capture slice.
package pnr_pkg;

  localparam int unsigned DW = 14;
  localparam int unsigned CW = 16;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WINDOW,
    REPORT
  } state_e;

endpackage

// File: rtl/pnr_edge_trigger.sv
// Registers the trigger channel and pulses trig_o for one cycle on a signed rising
// threshold crossing; stays quiet until two post-reset samples are held.
module pnr_edge_trigger #(
  parameter int unsigned DW = pnr_pkg::DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] adc_b_i,
  input  logic [DW-1:0] level_i,
  output logic          trig_o
);

  logic signed [DW-1:0] sb_q;
  logic signed [DW-1:0] sb_prev_q;
  logic signed [DW-1:0] level;
  logic [1:0]           fill_q;

  assign level = $signed(level_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q      <= '0;
      sb_prev_q <= '0;
      fill_q    <= '0;
    end else begin
      sb_q      <= $signed(adc_b_i);
      sb_prev_q <= sb_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  // fill_q[1] marks sb_prev_q as holding a real sample rather than the reset value
  assign trig_o = fill_q[1] && (sb_prev_q < level) && (sb_q >= level);

endmodule

// File: rtl/pnr_peak_capture.sv
// Captures the signed maximum of channel A over a delayed window after each accepted
// channel-B threshold crossing, and counts triggers rejected while busy.
module pnr_peak_capture
  import pnr_pkg::*;
#(
  parameter int unsigned DW = pnr_pkg::DW,
  parameter int unsigned CW = pnr_pkg::CW
) (
  input  logic          ADC_CLK,
  input  logic          RST,
  input  logic [DW-1:0] ADC_A,
  input  logic [DW-1:0] ADC_B,
  input  logic [DW-1:0] TRIG_LEVEL,
  input  logic [CW-1:0] TRIG_DELAY,
  input  logic [CW-1:0] WIN_LEN,
  output logic [DW-1:0] PEAK,
  output logic [CW-1:0] PEAK_POS,
  output logic          PEAK_VALID,
  output logic          BUSY,
  output logic [CW-1:0] MISSED_CNT
);

  state_e               state_q, state_d;
  logic signed [DW-1:0] sa_q;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [DW-1:0] peak_q, peak_d;
  logic [CW-1:0]        pos_q, pos_d;
  logic [CW-1:0]        peak_pos_q, peak_pos_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        dly_q, dly_d;
  logic [CW-1:0]        len_q, len_d;
  logic [CW-1:0]        missed_q, missed_d;
  logic                 trig;

  pnr_edge_trigger #(.DW(DW)) u_trig (
    .clk_i   (ADC_CLK),
    .rst_i   (RST),
    .adc_b_i (ADC_B),
    .level_i (TRIG_LEVEL),
    .trig_o  (trig)
  );

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      max_q      <= '0;
      pos_q      <= '0;
      cnt_q      <= '0;
      dly_q      <= '0;
      len_q      <= '0;
      peak_q     <= '0;
      peak_pos_q <= '0;
      missed_q   <= '0;
    end else begin
      state_q    <= state_d;
      sa_q       <= $signed(ADC_A);
      max_q      <= max_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      len_q      <= len_d;
      peak_q     <= peak_d;
      peak_pos_q <= peak_pos_d;
      missed_q   <= missed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    len_d      = len_q;
    peak_d     = peak_q;
    peak_pos_d = peak_pos_q;
    missed_d   = missed_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          len_d = (WIN_LEN == '0) ? CW'(1) : WIN_LEN;
          if (TRIG_DELAY == '0) begin
            max_d   = sa_q;
            pos_d   = '0;
            cnt_d   = CW'(1);
            state_d = (len_d == CW'(1)) ? REPORT : WINDOW;
          end else begin
            dly_d   = TRIG_DELAY - CW'(1);
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          max_d   = sa_q;
          pos_d   = '0;
          cnt_d   = CW'(1);
          state_d = (len_q == CW'(1)) ? REPORT : WINDOW;
        end else begin
          dly_d = dly_q - CW'(1);
        end
      end
      WINDOW: begin
        if (sa_q > max_q) begin
          max_d = sa_q;
          pos_d = cnt_q;
        end
        cnt_d = cnt_q + CW'(1);
        // cnt_q counts samples already taken, so this one is the last when it equals L-1
        if (cnt_q == len_q - CW'(1)) state_d = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result registers load on entry to REPORT and hold until the next one
    if (state_d == REPORT) begin
      peak_d     = max_d;
      peak_pos_d = pos_d;
    end

    if (trig && (state_q != IDLE) && (missed_q != '1)) missed_d = missed_q + CW'(1);
  end

  assign PEAK       = peak_q;
  assign PEAK_POS   = peak_pos_q;
  assign PEAK_VALID = (state_q == REPORT);
  assign BUSY       = (state_q != IDLE);
  assign MISSED_CNT = missed_q;

endmodule

// File: tb/tb_pnr_peak_capture.sv
// Directed bench for pnr_peak_capture: per-scenario A/B sample tables indexed by the
// pin cycle relative to the B crossing, with hand-computed event timing and peaks.
module tb_pnr_peak_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] adc_a, adc_b, trig_level;
  logic [15:0] trig_delay, win_len;
  logic [13:0] peak;
  logic [15:0] peak_pos, missed_cnt;
  logic        peak_valid, busy;

  int checks = 0;
  int errors = 0;

  logic signed [13:0] a_v [64];
  logic signed [13:0] b_v [64];
  int rel;
  int chg_at;
  int vcnt, vfirst, vlast, vpeak, vpos, bcnt, bfirst, blast;

  always #5 clk = ~clk;

  pnr_peak_capture #(.DW(14), .CW(16)) dut (
    .ADC_CLK    (clk),
    .RST        (rst),
    .ADC_A      (adc_a),
    .ADC_B      (adc_b),
    .TRIG_LEVEL (trig_level),
    .TRIG_DELAY (trig_delay),
    .WIN_LEN    (win_len),
    .PEAK       (peak),
    .PEAK_POS   (peak_pos),
    .PEAK_VALID (peak_valid),
    .BUSY       (busy),
    .MISSED_CNT (missed_cnt)
  );

  function automatic logic signed [13:0] s14(input int v);
    return v[13:0];
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of pin samples, pass the clock edge, land 1 time unit after it.
  task automatic step(input logic signed [13:0] a, input logic signed [13:0] b);
    adc_a = a;
    adc_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic preroll(input int a, input int b);
    for (int i = 0; i < 3; i++) step(s14(a), s14(b));
  endtask

  task automatic fill(input int a, input int b);
    for (int i = 0; i < 64; i++) begin
      a_v[i] = s14(a);
      b_v[i] = s14(b);
    end
  endtask

  // Drives table entries 0..n-1 (entry 0 is pin cycle t) and records events by cycle.
  task automatic run_seq(input int n);
    vcnt = 0; vfirst = -1; vlast = -1; vpeak = 0; vpos = 0;
    bcnt = 0; bfirst = -1; blast = -1;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) begin
        win_len    = 16'd2;
        trig_delay = 16'd0;
      end
      step(a_v[i], b_v[i]);
      rel = i + 1;
      if (peak_valid) begin
        vcnt++;
        if (vfirst < 0) vfirst = rel;
        vlast = rel;
        vpeak = int'($signed(peak));
        vpos  = int'(peak_pos);
      end
      if (busy) begin
        bcnt++;
        if (bfirst < 0) bfirst = rel;
        blast = rel;
      end
    end
  endtask

  initial begin
    rst = 1'b1; adc_a = '0; adc_b = '0; chg_at = -1;
    trig_level = 14'd1000; trig_delay = 16'd5; win_len = 16'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak", int'($signed(peak)), 0);
    chk("rst_pos", int'(peak_pos), 0);
    chk("rst_valid", int'(peak_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_missed", int'(missed_cnt), 0);
    rst = 1'b0;

    // Basic capture: D=5 L=8, ramp with 500 at t+7
    preroll(0, 0);
    fill(0, 2000);
    for (int i = 5; i < 13; i++) a_v[i] = s14((i == 7) ? 500 : i - 5);
    run_seq(20);
    chk("basic_vcnt", vcnt, 1);
    chk("basic_vat", vfirst, 14);
    chk("basic_peak", vpeak, 500);
    chk("basic_pos", vpos, 2);
    chk("basic_busy_first", bfirst, 2);
    chk("basic_busy_last", blast, 14);
    chk("basic_busy_cnt", bcnt, 13);

    // D=0, L=0 -> single sample window at t
    trig_delay = 16'd0; win_len = 16'd0;
    preroll(-8192, 0);
    fill(-8192, 2000);
    a_v[0] = s14(8191);
    run_seq(8);
    chk("d0_vat", vfirst, 2);
    chk("d0_vcnt", vcnt, 1);
    chk("d0_peak", vpeak, 8191);
    chk("d0_pos", vpos, 0);
    chk("d0_busy_cnt", bcnt, 1);
    chk("d0_hold_peak", int'($signed(peak)), 8191);

    // Tie: first maximum wins
    trig_delay = 16'd2; win_len = 16'd4;
    preroll(0, 0);
    fill(0, 2000);
    a_v[2] = s14(300); a_v[3] = s14(700); a_v[4] = s14(700); a_v[5] = s14(100);
    run_seq(12);
    chk("tie_vat", vfirst, 7);
    chk("tie_peak", vpeak, 700);
    chk("tie_pos", vpos, 1);

    // Missed triggers: crossings at t, t+6, t+20 (REPORT cycle detection)
    trig_delay = 16'd10; win_len = 16'd10;
    preroll(0, 0);
    fill(0, 2000);
    for (int i = 0; i < 64; i++) a_v[i] = s14(i);
    for (int i = 3; i < 6; i++) b_v[i] = s14(0);
    for (int i = 15; i < 20; i++) b_v[i] = s14(0);
    run_seq(30);
    chk("miss_vcnt", vcnt, 1);
    chk("miss_vat", vfirst, 21);
    chk("miss_cnt", int'(missed_cnt), 2);
    chk("miss_peak", vpeak, 19);
    chk("miss_pos", vpos, 9);

    // Crossing at t+21 is accepted
    preroll(0, 0);
    fill(0, 2000);
    for (int i = 0; i < 64; i++) a_v[i] = s14(i);
    b_v[19] = s14(0); b_v[20] = s14(0);
    run_seq(45);
    chk("next_vcnt", vcnt, 2);
    chk("next_vfirst", vfirst, 21);
    chk("next_vlast", vlast, 42);
    chk("next_peak", vpeak, 40);
    chk("next_missed", int'(missed_cnt), 2);

    // Level held high, WIN_LEN/TRIG_DELAY changed mid-capture
    trig_delay = 16'd3; win_len = 16'd5;
    preroll(0, 0);
    fill(0, 2000);
    for (int i = 0; i < 64; i++) a_v[i] = s14(i);
    a_v[7] = s14(900);
    chg_at = 3;
    run_seq(30);
    chg_at = -1;
    chk("hold_vcnt", vcnt, 1);
    chk("hold_vat", vfirst, 9);
    chk("hold_peak", vpeak, 900);
    chk("hold_pos", vpos, 4);

    // Full-scale compare: level +8191, B from -8192, negative window values
    trig_level = s14(8191); trig_delay = 16'd1; win_len = 16'd3;
    preroll(-8192, -8192);
    fill(-8192, 8191);
    a_v[2] = s14(-1);
    run_seq(10);
    chk("fs_vat", vfirst, 5);
    chk("fs_peak", vpeak, -1);
    chk("fs_pos", vpos, 1);

    // Reset during WINDOW, B stays above level across release
    trig_level = 14'd1000; trig_delay = 16'd2; win_len = 16'd10;
    preroll(0, 0);
    fill(0, 2000);
    run_seq(6);
    chk("rstw_busy_pre", int'(busy), 1);
    rst = 1'b1;
    step(s14(0), s14(2000));
    rst = 1'b0;
    chk("rstw_busy", int'(busy), 0);
    chk("rstw_valid", int'(peak_valid), 0);
    chk("rstw_missed", int'(missed_cnt), 0);
    chk("rstw_peak", int'($signed(peak)), 0);
    fill(0, 2000);
    run_seq(20);
    chk("rstw_after_busy", bcnt, 0);
    chk("rstw_after_vcnt", vcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pnr_peak_capture.md
Name: pnr_peak_capture

Overview:
- Analysis stage fed directly by the two 14-bit Red Pitaya ADC channels that enter PNR_main.
- Watches channel B (laser sync / reference) for a rising threshold crossing.
- After a programmable delay, captures the maximum of channel A (detector output) over a programmable window.
- Emits one peak-height event per accepted trigger; downstream photon-number binning and histogramming consume these events.

Parameters:
- DW, 14, ADC sample width; samples are signed two's complement.
- CW, 16, width of the delay counter, the window counter, PEAK_POS and MISSED_CNT.

Ports:
- ADC_CLK  in  1  ADC sample clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- ADC_A  in  DW  detector channel sample, signed.
- ADC_B  in  DW  trigger channel sample, signed.
- TRIG_LEVEL  in  DW  signed trigger threshold on ADC_B.
- TRIG_DELAY  in  CW  cycles from trigger to the first window sample (D).
- WIN_LEN  in  CW  window length in samples (L); 0 is treated as 1.
- PEAK  out  DW  signed maximum of ADC_A within the window.
- PEAK_POS  out  CW  index within the window (0..L-1) of the first occurrence of the maximum.
- PEAK_VALID  out  1  one-cycle strobe; PEAK and PEAK_POS are valid in this cycle.
- BUSY  out  1  high while a capture is in progress (state != IDLE).
- MISSED_CNT  out  CW  saturating count of triggers rejected while busy.

Behaviour:
- Clock and reset: one clock (ADC_CLK); reset RST is synchronous and active-high.
- Input registration: ADC_A and ADC_B are registered once (sa, sb); all logic operates on sa and sb.
- Trigger condition: sb_prev < TRIG_LEVEL and sb >= TRIG_LEVEL, compared signed.
- Detection is suppressed for the first cycle after reset until sb_prev holds a real sample.
- Timing reference: t is the pin cycle of the ADC_B crossing sample. Detection occurs at cycle t+1.
- Trigger acceptance:
  - A trigger is accepted only if state == IDLE in its detection cycle.
  - On acceptance, TRIG_DELAY and WIN_LEN are latched. Later config changes do not affect the capture in progress.
- States:
  - IDLE: on an accepted trigger with D == 0, load max = sa, pos = 0, count = 1, and go to WINDOW (or REPORT if L == 1). With D > 0, load delay counter and go to DELAY.
  - DELAY: count D-1 further cycles. On the last one, sa is pin sample t+D; load max/pos/count as above.
  - WINDOW: each cycle compare sa against max. Update only on strictly greater, so the first maximum wins and pos = count. After L samples in total go to REPORT.
  - REPORT: for one cycle, PEAK_VALID = 1 and PEAK/PEAK_POS are driven; then go to IDLE.
- Window and latency:
  - The window covers pin samples of ADC_A at t+D .. t+D+L-1.
  - PEAK_VALID is high at cycle t+D+L+1.
  - BUSY is high from t+2 through t+D+L+1 inclusive.
  - The next acceptable crossing is at pin cycle t+D+L+1 or later.
- Missed triggers: a trigger detected while not in IDLE, including the REPORT cycle, increments MISSED_CNT. The count saturates at 2^CW-1 and is cleared only by RST.
- Output hold: PEAK and PEAK_POS hold their last values until the next REPORT.
- Reset values: PEAK = 0, PEAK_POS = 0, PEAK_VALID = 0, BUSY = 0, MISSED_CNT = 0, state = IDLE.
- Reset mid-capture abandons the capture with no PEAK_VALID.
- Width rules:
  - Window counter and position are CW bits. L = 2^CW-1 must work without wrap.
  - No arithmetic on sample values, only signed compare.
  - Full-scale values -8192 and +8191 must compare correctly.

Decomposition:
- Shared package pnr_pkg holds DW, CW, the state encoding (IDLE, DELAY, WINDOW, REPORT) and the signed sample typedef.
- Sub-module pnr_edge_trigger holds the sb/sb_prev registers, the signed threshold compare and the post-reset suppression. Its output is a one-cycle trig pulse.

Test Plan:
- Basic capture: TRIG_LEVEL=1000, D=5, L=8, B steps 0 -> 2000 at t. ADC_A ramp 0..7 from t+5, except value 500 at t+7 -> PEAK=500, PEAK_POS=2, PEAK_VALID at t+14, BUSY t+2..t+14.
- D=0 and L=0: crossing at t, A=-8192 everywhere except +8191 at t -> window is the single sample, PEAK=8191, PEAK_POS=0, valid at t+2.
- Tie handling: L=4, window A = 300, 700, 700, 100 -> PEAK=700, PEAK_POS=1.
- Missed triggers: D=10, L=10, second crossing at t+6 and third at t+20 (the REPORT cycle t+21 detection) -> MISSED_CNT=2, one PEAK_VALID. A crossing at t+21 is accepted.
- Level hold and config change: B held above level with no re-crossing -> no second trigger. WIN_LEN changed mid-capture -> the latched L is used.
- Reset: RST asserted during WINDOW -> next cycle BUSY=0, no PEAK_VALID, MISSED_CNT=0. B already above level at reset release -> no trigger.
